usbdev_in_ep_ctrl: RTL and testbench
====================================

# usbdev_in_ep_ctrl

Per-endpoint IN packet controller between software configuration registers, the packet buffer SRAM and the non-buffered IN protocol engine. Holds the buffer ID, size and ready state of one packet per IN endpoint, and presents `has_data` and `data_done` to the engine. It fetches 32-bit SRAM words on demand and serves bytes by `get_addr`. On each transaction outcome it either retires the packet or leaves it queued for retry.

## Interface
Parameters:
- NumInEps, 12, number of implemented IN endpoints
- MaxInPktSizeByte, 32, max packet bytes; PktW = $clog2(MaxInPktSizeByte)
- NumBufs, 32, SRAM packet buffers; BufW = $clog2(NumBufs)
- MemAw, BufW+PktW-2, SRAM word address width

Ports:
- clk_48mhz_i  in  1  clock
- rst_ni  in  1  reset; rst_ni asynchronous, active-low; clock clk_48mhz_i
- link_reset_i  in  1  bus reset; synchronous clear of all endpoint state
- cfg_we_i  in  1  software write strobe
- cfg_ep_i  in  4  endpoint being written
- cfg_buf_i  in  BufW  buffer ID
- cfg_size_i  in  PktW+1  packet length, 0..MaxInPktSizeByte
- cfg_rdy_i  in  1  1 = arm packet, 0 = cancel
- cfg_err_o  out  1  pulse: write rejected
- rdy_o  out  NumInEps  per-endpoint armed flags
- pkt_sent_o  out  NumInEps  one-cycle pulse per completed packet
- in_xact_starting_i, in_xact_start_ep_i[3:0], in_ep_current_i[3:0], in_ep_rollback_i, in_ep_xact_end_i, in_ep_get_addr_i[PktW-1:0]  in  from protocol engine
- in_ep_has_data_o  out  NumInEps  equals rdy_o
- in_ep_data_done_o  out  NumInEps  bit[in_ep_current_i] = (get_addr ≥ size); other bits 0
- in_ep_data_o  out  8  byte at get_addr of current packet
- mem_req_o  out  1  read request
- mem_addr_o  out  MemAw  {buf, get_addr[PktW-1:2]}
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  32  read data, little-endian bytes

## Operation
- Per-endpoint registers: buf_q, size_q, rdy_q, busy_q.
- busy_q[e] is set by in_xact_starting_i with ep e. It is cleared by xact_end, by rollback, or by a new start on a different ep. At most one bit is set.
- Software write, busy_q[cfg_ep_i]=0, ep < NumInEps: load buf and size, set rdy_q to cfg_rdy_i.
- Software write is rejected with a cfg_err_o pulse and no state change when the ep is busy or cfg_ep_i ≥ NumInEps.
- in_ep_xact_end_i: clear rdy_q[current], pulse pkt_sent_o[current], clear busy.
- in_ep_rollback_i: clear busy only; packet stays armed for retry.
- Fetch FSM with states StIdle, StReq, StWait, StHold:
  - StIdle→StReq on in_xact_starting_i with rdy set.
  - StReq: mem_req_o=1 until mem_gnt_i, then →StWait.
  - StWait: on mem_rvalid_i latch word and word index, →StHold.
  - StHold→StReq when get_addr[PktW-1:2] ≠ held index.
  - Any state→StIdle on xact_end, rollback or link_reset_i. The outstanding flag stays set until rvalid, so a late rvalid is discarded.
- in_ep_data_o = held word byte get_addr[1:0] in StHold; otherwise 0.
- Size 0 packet: data_done is immediate; no fetch is issued.

## Timing
- Reset/link_reset: all outputs 0, rdy/busy/buf/size 0, FSM StIdle.
- First word requested the cycle after in_xact_starting_i. Byte valid in StHold ≤ SRAM latency + 2 cycles, well under the 32-cycle byte period.
- Cfg write takes effect next cycle. A simultaneous xact_end and write to the same ep is rejected, because busy is still set.
- pkt_sent_o pulses the cycle after in_ep_xact_end_i.

## Structure
- The fetch state enum and the endpoint config struct (buf, size, rdy) belong in usbdev_pkg.
- Sub-module: usbdev_in_word_fetch, containing the fetch FSM, req/gnt/rvalid handling and the word hold register.

## Test plan
- Arm ep2 with buf 5, size 7, then an IN/ACK sequence → mem_addr_o {5,0} then {5,1}; bytes match SRAM; data_done at get_addr 7; pkt_sent_o[2] pulses; rdy_o[2]=0.
- Arm ep1, then a transaction ending in rollback (timeout) → rdy_o[1] stays 1, no pkt_sent; retry delivers the same bytes.
- Cfg write to ep1 while busy → cfg_err_o=1 and config unchanged. Cfg write with cfg_ep_i=13 → cfg_err_o=1.
- Size 0 on ep0 → data_done immediate, mem_req_o never asserted, pkt_sent_o[0] on ACK.
- link_reset_i while in StWait, then late mem_rvalid_i → all rdy cleared, in_ep_data_o=0, late data ignored.
- 4-cycle mem_gnt_i stall → mem_req_o held with a stable address; first byte is still correct.

Source files
------------

// File: rtl/usbdev_pkg.sv
// Shared types for the USB device IN endpoint datapath.
//   - Default sizing of the IN endpoint block (endpoints, packet size, buffers).
//   - Word-fetch FSM state encoding.
//   - Per-endpoint packet configuration record (buffer ID, size, armed flag).
package usbdev_pkg;

    localparam int unsigned UsbNumInEps         = 12;
    localparam int unsigned UsbMaxInPktSizeByte = 32;
    localparam int unsigned UsbNumBufs          = 32;
    localparam int unsigned UsbPktW             = $clog2(UsbMaxInPktSizeByte);
    localparam int unsigned UsbBufW             = $clog2(UsbNumBufs);
    localparam int unsigned UsbMemAw            = UsbBufW + UsbPktW - 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StHold = 2'd3
    } in_fetch_state_e;

    // size is one bit wider than a byte address so a full-length packet fits
    typedef struct packed {
        logic [UsbBufW-1:0] buf_id;
        logic [UsbPktW:0]   size;
        logic               rdy;
    } in_ep_cfg_t;

endpackage

// File: rtl/usbdev_in_word_fetch.sv
// On-demand SRAM word fetcher for the IN packet currently being sent.
// Ports:
//   clk_48mhz_i, rst_ni     clock, async active-low reset
//   start_i, start_buf_i    begin fetching the packet held in buffer start_buf_i
//   abort_i                 drop the current fetch (transaction over / link reset)
//   get_addr_i              byte address requested by the protocol engine
//   mem_*                   SRAM read port (req/gnt handshake, rvalid return)
//   data_o                  byte at get_addr_i while a word is held, else 0
module usbdev_in_word_fetch
    import usbdev_pkg::*;
#(
    parameter  int unsigned PktW  = UsbPktW,
    parameter  int unsigned BufW  = UsbBufW,
    localparam int unsigned MemAw = BufW + PktW - 2
) (
    input  logic             clk_48mhz_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [BufW-1:0]  start_buf_i,
    input  logic [PktW-1:0]  get_addr_i,
    output logic             mem_req_o,
    output logic [MemAw-1:0] mem_addr_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [31:0]      mem_rdata_i,
    output logic [7:0]       data_o
);

    localparam int unsigned WordIdxW = PktW - 2;

    in_fetch_state_e     state_q, state_d;
    logic [BufW-1:0]     buf_q;
    logic [WordIdxW-1:0] req_idx_q;
    logic [WordIdxW-1:0] hold_idx_q;
    logic [31:0]         hold_word_q;
    logic                outstanding_q;
    logic [WordIdxW-1:0] addr_idx_c;

    assign addr_idx_c = get_addr_i[PktW-1:2];

    // State register
    always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; abort beats a restart, a restart beats normal progress
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  state_d = StIdle;
            StReq:   if (!outstanding_q && mem_gnt_i) state_d = StWait;
            StWait:  if (mem_rvalid_i) state_d = StHold;
            StHold:  if (addr_idx_c != hold_idx_q) state_d = StReq;
            default: state_d = StIdle;
        endcase
        if (start_i) state_d = StReq;
        if (abort_i) state_d = StIdle;
    end

    // Outputs; a request is withheld while an abandoned read is still in flight
    always_comb begin
        mem_req_o  = (state_q == StReq) && !outstanding_q;
        mem_addr_o = {buf_q, req_idx_q};
        data_o     = '0;
        if (state_q == StHold) data_o = hold_word_q[{get_addr_i[1:0], 3'b000} +: 8];
    end

    // Fetch datapath: request index frozen for the whole req phase, word hold
    always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q         <= '0;
            req_idx_q     <= '0;
            hold_idx_q    <= '0;
            hold_word_q   <= '0;
            outstanding_q <= 1'b0;
        end else begin
            if (start_i) buf_q <= start_buf_i;
            if (start_i || (state_d == StReq && state_q != StReq)) req_idx_q <= addr_idx_c;
            if (state_q == StWait && mem_rvalid_i) begin
                hold_word_q <= mem_rdata_i;
                hold_idx_q  <= req_idx_q;
            end
            if (mem_req_o && mem_gnt_i) begin
                outstanding_q <= 1'b1;
            end else if (mem_rvalid_i) begin
                outstanding_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/usbdev_in_ep_ctrl.sv
// Per-endpoint IN packet controller: holds one armed packet per IN endpoint,
// serves its bytes to the protocol engine from SRAM, retires it on ACK and
// keeps it armed on rollback.
// Ports:
//   clk_48mhz_i, rst_ni, link_reset_i   clock, async reset, bus-reset clear
//   cfg_*                               software arm/cancel write, cfg_err_o on reject
//   rdy_o, pkt_sent_o                   armed flags, packet-retired pulses
//   in_*                                protocol engine handshake and byte path
//   mem_*                               packet buffer SRAM read port
module usbdev_in_ep_ctrl
    import usbdev_pkg::*;
#(
    parameter  int unsigned NumInEps         = UsbNumInEps,
    parameter  int unsigned MaxInPktSizeByte = UsbMaxInPktSizeByte,
    parameter  int unsigned NumBufs          = UsbNumBufs,
    localparam int unsigned PktW             = $clog2(MaxInPktSizeByte),
    localparam int unsigned BufW             = $clog2(NumBufs),
    localparam int unsigned MemAw            = BufW + PktW - 2
) (
    input  logic                clk_48mhz_i,
    input  logic                rst_ni,
    input  logic                link_reset_i,
    input  logic                cfg_we_i,
    input  logic [3:0]          cfg_ep_i,
    input  logic [BufW-1:0]     cfg_buf_i,
    input  logic [PktW:0]       cfg_size_i,
    input  logic                cfg_rdy_i,
    output logic                cfg_err_o,
    output logic [NumInEps-1:0] rdy_o,
    output logic [NumInEps-1:0] pkt_sent_o,
    input  logic                in_xact_starting_i,
    input  logic [3:0]          in_xact_start_ep_i,
    input  logic [3:0]          in_ep_current_i,
    input  logic                in_ep_rollback_i,
    input  logic                in_ep_xact_end_i,
    input  logic [PktW-1:0]     in_ep_get_addr_i,
    output logic [NumInEps-1:0] in_ep_has_data_o,
    output logic [NumInEps-1:0] in_ep_data_done_o,
    output logic [7:0]          in_ep_data_o,
    output logic                mem_req_o,
    output logic [MemAw-1:0]    mem_addr_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [31:0]         mem_rdata_i
);

    in_ep_cfg_t          cfg_q [NumInEps];
    in_ep_cfg_t          cfg_d [NumInEps];
    logic [NumInEps-1:0] busy_q, busy_d;
    logic [NumInEps-1:0] pkt_sent_d;
    logic                cfg_err_d;
    logic                cfg_busy_c, cfg_accept_c;
    logic                fetch_start_c, fetch_abort_c;
    logic [BufW-1:0]     start_buf_c;

    // A write is taken only for an implemented, non-busy endpoint
    always_comb begin
        cfg_busy_c = 1'b0;
        for (int unsigned e = 0; e < NumInEps; e++) begin
            if (cfg_ep_i == 4'(e)) cfg_busy_c = busy_q[e];
        end
        cfg_accept_c = cfg_we_i && (32'(cfg_ep_i) < NumInEps) && !cfg_busy_c;
    end

    // Endpoint state update; an accepted write overrides a retire of the same ep
    always_comb begin
        cfg_d      = cfg_q;
        busy_d     = busy_q;
        pkt_sent_d = '0;
        cfg_err_d  = cfg_we_i && !cfg_accept_c;
        if (in_ep_xact_end_i || in_ep_rollback_i || in_xact_starting_i) busy_d = '0;
        for (int unsigned e = 0; e < NumInEps; e++) begin
            if (in_xact_starting_i && in_xact_start_ep_i == 4'(e)) busy_d[e] = 1'b1;
            if (in_ep_xact_end_i && in_ep_current_i == 4'(e)) begin
                cfg_d[e].rdy  = 1'b0;
                pkt_sent_d[e] = 1'b1;
            end
            if (cfg_accept_c && cfg_ep_i == 4'(e)) begin
                cfg_d[e] = '{buf_id: cfg_buf_i, size: cfg_size_i, rdy: cfg_rdy_i};
            end
        end
        if (link_reset_i) begin
            for (int unsigned e = 0; e < NumInEps; e++) cfg_d[e] = '0;
            busy_d     = '0;
            pkt_sent_d = '0;
            cfg_err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned e = 0; e < NumInEps; e++) cfg_q[e] <= '0;
            busy_q     <= '0;
            pkt_sent_o <= '0;
            cfg_err_o  <= 1'b0;
        end else begin
            cfg_q      <= cfg_d;
            busy_q     <= busy_d;
            pkt_sent_o <= pkt_sent_d;
            cfg_err_o  <= cfg_err_d;
        end
    end

    // Fetch only for an armed, non-empty packet; any other start cancels the fetch
    always_comb begin
        fetch_start_c = 1'b0;
        start_buf_c   = '0;
        for (int unsigned e = 0; e < NumInEps; e++) begin
            if (in_xact_start_ep_i == 4'(e)) begin
                start_buf_c   = cfg_q[e].buf_id;
                fetch_start_c = in_xact_starting_i && cfg_q[e].rdy && (cfg_q[e].size != '0);
            end
        end
        fetch_abort_c = in_ep_xact_end_i || in_ep_rollback_i || link_reset_i ||
                        (in_xact_starting_i && !fetch_start_c);
    end

    // Armed flags and done indication; done is only meaningful for an armed packet
    always_comb begin
        in_ep_data_done_o = '0;
        for (int unsigned e = 0; e < NumInEps; e++) begin
            rdy_o[e] = cfg_q[e].rdy;
            if (in_ep_current_i == 4'(e)) begin
                in_ep_data_done_o[e] = cfg_q[e].rdy && ({1'b0, in_ep_get_addr_i} >= cfg_q[e].size);
            end
        end
        in_ep_has_data_o = rdy_o;
    end

    usbdev_in_word_fetch #(
        .PktW (PktW),
        .BufW (BufW)
    ) u_word_fetch (
        .clk_48mhz_i  (clk_48mhz_i),
        .rst_ni       (rst_ni),
        .start_i      (fetch_start_c),
        .abort_i      (fetch_abort_c),
        .start_buf_i  (start_buf_c),
        .get_addr_i   (in_ep_get_addr_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .data_o       (in_ep_data_o)
    );

endmodule

// File: tb/tb_usbdev_in_ep_ctrl.sv
// Self-checking bench for usbdev_in_ep_ctrl: table of configuration writes,
// then hand-written IN transaction sequences against a small SRAM model.
module tb_usbdev_in_ep_ctrl;

    localparam int unsigned NEp = 12;

    logic        clk_48mhz_i = 1'b0;
    logic        rst_ni;
    logic        link_reset_i;
    logic        cfg_we_i;
    logic [3:0]  cfg_ep_i;
    logic [4:0]  cfg_buf_i;
    logic [5:0]  cfg_size_i;
    logic        cfg_rdy_i;
    logic        cfg_err_o;
    logic [11:0] rdy_o;
    logic [11:0] pkt_sent_o;
    logic        in_xact_starting_i;
    logic [3:0]  in_xact_start_ep_i;
    logic [3:0]  in_ep_current_i;
    logic        in_ep_rollback_i;
    logic        in_ep_xact_end_i;
    logic [4:0]  in_ep_get_addr_i;
    logic [11:0] in_ep_has_data_o;
    logic [11:0] in_ep_data_done_o;
    logic [7:0]  in_ep_data_o;
    logic        mem_req_o;
    logic [7:0]  mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 clk_48mhz_i = ~clk_48mhz_i;

    usbdev_in_ep_ctrl dut (
        .clk_48mhz_i        (clk_48mhz_i),
        .rst_ni             (rst_ni),
        .link_reset_i       (link_reset_i),
        .cfg_we_i           (cfg_we_i),
        .cfg_ep_i           (cfg_ep_i),
        .cfg_buf_i          (cfg_buf_i),
        .cfg_size_i         (cfg_size_i),
        .cfg_rdy_i          (cfg_rdy_i),
        .cfg_err_o          (cfg_err_o),
        .rdy_o              (rdy_o),
        .pkt_sent_o         (pkt_sent_o),
        .in_xact_starting_i (in_xact_starting_i),
        .in_xact_start_ep_i (in_xact_start_ep_i),
        .in_ep_current_i    (in_ep_current_i),
        .in_ep_rollback_i   (in_ep_rollback_i),
        .in_ep_xact_end_i   (in_ep_xact_end_i),
        .in_ep_get_addr_i   (in_ep_get_addr_i),
        .in_ep_has_data_o   (in_ep_has_data_o),
        .in_ep_data_done_o  (in_ep_data_done_o),
        .in_ep_data_o       (in_ep_data_o),
        .mem_req_o          (mem_req_o),
        .mem_addr_o         (mem_addr_o),
        .mem_gnt_i          (mem_gnt_i),
        .mem_rvalid_i       (mem_rvalid_i),
        .mem_rdata_i        (mem_rdata_i)
    );

    // SRAM contents: a fixed scramble of buffer and byte offset
    function automatic logic [7:0] bval(input int b, input int a);
        return 8'((b * 37 + a * 11 + 5) % 256);
    endfunction

    function automatic logic [31:0] word_of(input logic [7:0] addr);
        int b;
        int w;
        b = int'(addr[7:3]);
        w = int'(addr[2:0]);
        return {bval(b, 4 * w + 3), bval(b, 4 * w + 2), bval(b, 4 * w + 1), bval(b, 4 * w)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_48mhz_i);
        #2;
    endtask

    // SRAM responder: optional grant stall, fixed read latency after the grant edge
    int          gnt_stall  = 0;
    int          rd_lat     = 0;
    int          stall_cnt  = 0;
    int          req_cycles = 0;
    bit          pend       = 1'b0;
    int          pend_cnt   = 0;
    logic [7:0]  pend_addr  = '0;
    logic [7:0]  gnt_addr   = '0;
    logic [7:0]  gnt_log[$];

    initial begin
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(posedge clk_48mhz_i);
            #1;
            mem_rvalid_i = 1'b0;
            if (mem_gnt_i) begin
                pend      = 1'b1;
                pend_addr = gnt_addr;
                pend_cnt  = rd_lat;
            end
            mem_gnt_i = 1'b0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = word_of(pend_addr);
                    pend         = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if (mem_req_o) begin
                req_cycles++;
                if (stall_cnt < gnt_stall) begin
                    stall_cnt++;
                end else begin
                    mem_gnt_i = 1'b1;
                    gnt_addr  = mem_addr_o;
                    gnt_log.push_back(mem_addr_o);
                    stall_cnt = 0;
                end
            end
        end
    end

    task automatic cfg_drive(input int ep, input int b, input int size, input bit rdy);
        cfg_we_i   = 1'b1;
        cfg_ep_i   = 4'(ep);
        cfg_buf_i  = 5'(b);
        cfg_size_i = 6'(size);
        cfg_rdy_i  = rdy;
    endtask

    task automatic cfg_idle();
        cfg_we_i = 1'b0;
    endtask

    task automatic arm(input int ep, input int b, input int size, input logic [11:0] exp_rdy);
        cfg_drive(ep, b, size, 1'b1);
        tick();
        cfg_idle();
        chk($sformatf("arm_ep%0d_err", ep), 32'(cfg_err_o), 0);
        chk($sformatf("arm_ep%0d_rdy", ep), 32'(rdy_o), 32'(exp_rdy));
    endtask

    task automatic start_xact(input int ep);
        in_xact_starting_i = 1'b1;
        in_xact_start_ep_i = 4'(ep);
        in_ep_current_i    = 4'(ep);
        in_ep_get_addr_i   = '0;
        tick();
        in_xact_starting_i = 1'b0;
    endtask

    // Walk get_addr through the packet, checking each byte and data_done
    task automatic run_bytes(input string tag, input int ep, input int b, input int size, input int waitc);
        for (int a = 0; a <= size; a++) begin
            in_ep_get_addr_i = 5'(a);
            repeat (waitc) tick();
            if (a < size) chk($sformatf("%s_byte%0d", tag, a), 32'(in_ep_data_o), 32'(bval(b, a)));
            chk($sformatf("%s_done%0d", tag, a), 32'(in_ep_data_done_o),
                (a >= size) ? (32'd1 << ep) : 32'd0);
        end
    endtask

    task automatic end_xact(input string tag, input logic [11:0] exp_sent, input logic [11:0] exp_rdy);
        in_ep_xact_end_i = 1'b1;
        tick();
        in_ep_xact_end_i = 1'b0;
        chk({tag, "_sent"}, 32'(pkt_sent_o), 32'(exp_sent));
        chk({tag, "_rdy"}, 32'(rdy_o), 32'(exp_rdy));
        tick();
        chk({tag, "_sent_clr"}, 32'(pkt_sent_o), 0);
    endtask

    typedef struct {
        logic [3:0]  ep;
        logic [4:0]  bufid;
        logic [5:0]  size;
        logic        rdy;
        logic        exp_err;
        logic [11:0] exp_rdy;
    } cfg_vec_t;

    localparam int NVec = 8;
    cfg_vec_t vec [NVec];

    initial begin
        vec[0] = '{4'd3,  5'd4, 6'd10, 1'b1, 1'b0, 12'h008};
        vec[1] = '{4'd11, 5'd9, 6'd32, 1'b1, 1'b0, 12'h808};
        vec[2] = '{4'd12, 5'd1, 6'd4,  1'b1, 1'b1, 12'h808};
        vec[3] = '{4'd13, 5'd2, 6'd4,  1'b1, 1'b1, 12'h808};
        vec[4] = '{4'd3,  5'd4, 6'd10, 1'b0, 1'b0, 12'h800};
        vec[5] = '{4'd15, 5'd0, 6'd1,  1'b1, 1'b1, 12'h800};
        vec[6] = '{4'd0,  5'd1, 6'd4,  1'b1, 1'b0, 12'h801};
        vec[7] = '{4'd11, 5'd9, 6'd32, 1'b0, 1'b0, 12'h001};

        rst_ni             = 1'b0;
        link_reset_i       = 1'b0;
        cfg_we_i           = 1'b0;
        cfg_ep_i           = '0;
        cfg_buf_i          = '0;
        cfg_size_i         = '0;
        cfg_rdy_i          = 1'b0;
        in_xact_starting_i = 1'b0;
        in_xact_start_ep_i = '0;
        in_ep_current_i    = '0;
        in_ep_rollback_i   = 1'b0;
        in_ep_xact_end_i   = 1'b0;
        in_ep_get_addr_i   = '0;
        repeat (3) tick();

        chk("rst_rdy",      32'(rdy_o), 0);
        chk("rst_has_data", 32'(in_ep_has_data_o), 0);
        chk("rst_sent",     32'(pkt_sent_o), 0);
        chk("rst_err",      32'(cfg_err_o), 0);
        chk("rst_done",     32'(in_ep_data_done_o), 0);
        chk("rst_data",     32'(in_ep_data_o), 0);
        chk("rst_req",      32'(mem_req_o), 0);
        rst_ni = 1'b1;
        tick();

        // Configuration write table
        for (int i = 0; i < NVec; i++) begin
            cfg_drive(int'(vec[i].ep), int'(vec[i].bufid), int'(vec[i].size), vec[i].rdy);
            tick();
            cfg_idle();
            chk($sformatf("vec%0d_err", i), 32'(cfg_err_o), 32'(vec[i].exp_err));
            chk($sformatf("vec%0d_rdy", i), 32'(rdy_o), 32'(vec[i].exp_rdy));
            chk($sformatf("vec%0d_has_data", i), 32'(in_ep_has_data_o), 32'(vec[i].exp_rdy));
            tick();
            chk($sformatf("vec%0d_err_pulse", i), 32'(cfg_err_o), 0);
        end
        link_reset_i = 1'b1;
        tick();
        link_reset_i = 1'b0;
        chk("lrst_rdy", 32'(rdy_o), 0);

        // ep2: buf 5, 7 bytes, ACKed
        arm(2, 5, 7, 12'h004);
        gnt_log.delete();
        start_xact(2);
        chk("a_req",  32'(mem_req_o), 1);
        chk("a_addr", 32'(mem_addr_o), 32'h28);
        run_bytes("a", 2, 5, 7, 5);
        chk("a_ngnt", gnt_log.size(), 2);
        chk("a_gnt0", 32'((gnt_log.size() > 0) ? gnt_log[0] : 8'hff), 32'h28);
        chk("a_gnt1", 32'((gnt_log.size() > 1) ? gnt_log[1] : 8'hff), 32'h29);
        end_xact("a", 12'h004, 12'h000);

        // ep1: rollback keeps the packet armed, busy write rejected
        arm(1, 7, 5, 12'h002);
        start_xact(1);
        cfg_drive(1, 3, 2, 1'b0);
        tick();
        cfg_idle();
        chk("b_busy_err", 32'(cfg_err_o), 1);
        chk("b_busy_rdy", 32'(rdy_o), 32'h002);
        run_bytes("b1", 1, 7, 5, 5);
        in_ep_rollback_i = 1'b1;
        tick();
        in_ep_rollback_i = 1'b0;
        chk("b_rb_sent", 32'(pkt_sent_o), 0);
        chk("b_rb_rdy",  32'(rdy_o), 32'h002);
        start_xact(1);
        run_bytes("b2", 1, 7, 5, 5);
        in_ep_xact_end_i = 1'b1;
        cfg_drive(1, 3, 2, 1'b1);
        tick();
        in_ep_xact_end_i = 1'b0;
        cfg_idle();
        chk("b_end_err",  32'(cfg_err_o), 1);
        chk("b_end_sent", 32'(pkt_sent_o), 32'h002);
        chk("b_end_rdy",  32'(rdy_o), 0);
        tick();

        // ep0: zero-length packet, no fetch
        arm(0, 2, 0, 12'h001);
        in_ep_current_i  = 4'd0;
        in_ep_get_addr_i = '0;
        #1;
        chk("c_done_now", 32'(in_ep_data_done_o), 32'h001);
        req_cycles = 0;
        start_xact(0);
        repeat (4) tick();
        chk("c_no_req", req_cycles, 0);
        chk("c_done",   32'(in_ep_data_done_o), 32'h001);
        end_xact("c", 12'h001, 12'h000);

        // ep4: link reset during StWait, stale read returns later
        arm(7, 1, 3, 12'h080);
        arm(4, 6, 8, 12'h090);
        rd_lat = 4;
        start_xact(4);
        tick();
        link_reset_i = 1'b1;
        rd_lat       = 0;
        tick();
        link_reset_i = 1'b0;
        chk("d_rdy",  32'(rdy_o), 0);
        chk("d_data", 32'(in_ep_data_o), 0);
        chk("d_done", 32'(in_ep_data_done_o), 0);
        chk("d_sent", 32'(pkt_sent_o), 0);
        chk("d_req",  32'(mem_req_o), 0);
        arm(4, 9, 8, 12'h010);
        start_xact(4);
        chk("d_req_blocked", 32'(mem_req_o), 0);
        chk("d_data_blk",    32'(in_ep_data_o), 0);
        tick();
        chk("d_data_stale",  32'(in_ep_data_o), 0);
        run_bytes("d", 4, 9, 8, 6);
        end_xact("d", 12'h010, 12'h000);

        // ep5: grant stalled for 4 cycles
        arm(5, 3, 4, 12'h020);
        gnt_stall = 4;
        start_xact(5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("e_req%0d", i),  32'(mem_req_o), 1);
            chk($sformatf("e_addr%0d", i), 32'(mem_addr_o), 32'h18);
            tick();
        end
        run_bytes("e", 5, 3, 4, 10);
        gnt_stall = 0;
        end_xact("e", 12'h020, 12'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
